// File: rtl/cnt_sched_if.sv
// Request/grant bundle between requesters and the shared run counter.
// The master drives requests, limits and abort; the slave returns grants, count and status.
interface cnt_sched_if;
   logic       req0;
   logic [3:0] lim0;
   logic       req1;
   logic [3:0] lim1;
   logic       abort;
   logic       gnt0;
   logic       gnt1;
   logic [3:0] q;
   logic       busy;
   logic       done0;
   logic       done1;

   modport master (
      output req0, lim0, req1, lim1, abort,
      input  gnt0, gnt1, q, busy, done0, done1
   );

   modport slave (
      input  req0, lim0, req1, lim1, abort,
      output gnt0, gnt1, q, busy, done0, done1
   );
endinterface

// File: rtl/cnt_sched.sv
// Two-requester round-robin scheduler for one shared up-counter.
// Each grant counts 0..limit, then issues a one-cycle done pulse to the owner.
module cnt_sched (
   input  logic        clk,
   input  logic        rst,
   cnt_sched_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e     state_q, state_d;
   logic [3:0] q_q, q_d;
   logic [3:0] lim_q, lim_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       busy_q, busy_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;

   logic       any_req;
   logic       pick;
   logic       at_lim;

   // On contention, grant whichever requester was not served last.
   assign any_req = bus.req0 | bus.req1;
   assign pick    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
   assign at_lim  = (q_q == lim_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         q_q     <= 4'd0;
         lim_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         lim_q   <= lim_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         busy_q  <= busy_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StRun;
         StRun: begin
            if (bus.abort)   state_d = StIdle;
            else if (at_lim) state_d = StFin;
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      q_d     = q_q;
      lim_d   = lim_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      busy_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               q_d     = 4'd0;
               lim_d   = pick ? bus.lim1 : bus.lim0;
               owner_d = pick;
               last_d  = pick;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               busy_d  = 1'b1;
            end
         end
         StRun: begin
            // Abort drops everything with Q frozen; terminal count never increments,
            // so Q cannot wrap even with limit 15.
            if (!bus.abort) begin
               busy_d = 1'b1;
               if (at_lim) begin
                  done0_d = ~owner_q;
                  done1_d = owner_q;
               end else begin
                  q_d    = q_q + 4'd1;
                  gnt0_d = ~owner_q;
                  gnt1_d = owner_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.q     = q_q;
   assign bus.busy  = busy_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-002 CLK  input  1  system clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 REQ0  input  1  requester 0 run request, level-sensitive.
REQ-005 LIM0  input  4  requester 0 terminal count, sampled at grant.
REQ-006 REQ1  input  1  requester 1 run request, level-sensitive.
REQ-007 LIM1  input  4  requester 1 terminal count, sampled at grant.
REQ-008 ABORT  input  1  cancel the current run.
REQ-009 GNT0  output  1  counter owned by requester 0; registered.
REQ-010 GNT1  output  1  counter owned by requester 1; registered.
REQ-011 Q  output  4  shared count value; registered.
REQ-012 BUSY  output  1  high in RUN and FIN; registered.
REQ-013 DONE0  output  1  one-cycle completion pulse for requester 0; registered.
REQ-014 DONE1  output  1  one-cycle completion pulse for requester 1; registered.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-016 In IDLE the outputs SHALL be GNTx=0, BUSY=0 and DONEx=0, and Q SHALL hold its last value.
REQ-017 In IDLE with any REQx=1 at an edge, the FSM SHALL go to RUN with Q<=0, assert the selected GNTx, set BUSY=1 and latch the selected LIMx into an internal limit register; the grant latency is one edge.
REQ-018 Arbitration SHALL be round-robin using a last-served pointer:
- a single requester is granted;
- when REQ0 and REQ1 are both high, the requester not served last is granted;
- the pointer updates on each grant.
REQ-019 In RUN with ABORT=1, the FSM SHALL go to IDLE: GNTx<=0, BUSY<=0, no DONE pulse, Q holds; ABORT has priority over the terminal-count check.
REQ-020 In RUN with Q equal to the latched limit, the FSM SHALL go to FIN: GNTx<=0, the owner's DONEx<=1, BUSY stays 1, Q holds.
REQ-021 In RUN otherwise, Q SHALL increment by 1; RUN lasts exactly limit+1 cycles (Q = 0..limit).
REQ-022 FIN SHALL last exactly one cycle and then go to IDLE with DONEx<=0 and BUSY<=0.
REQ-023 GNT0 and GNT1 SHALL never be high together, and DONE0 and DONE1 SHALL never be high together.
REQ-024 Changes on LIMx or the owner's REQx during RUN or FIN SHALL be ignored, so a run always completes or aborts.
REQ-025 Q SHALL never wrap: with limit=15, Q reaches 15, then FIN, with no 15->0 transition.
REQ-026 With limit=0, RUN SHALL last one cycle (Q=0), followed by FIN.
REQ-027 ABORT in IDLE or FIN SHALL have no effect.
REQ-028 A REQx still high after FIN SHALL be re-arbitrated in IDLE, giving at least one IDLE cycle between runs.

Reset
REQ-029 RST=1 at an edge SHALL override all other inputs, including mid-run.
REQ-030 On reset the block SHALL enter IDLE with Q=0, GNT0=GNT1=0, BUSY=0, DONE0=DONE1=0 and the limit register at 0.
REQ-031 On reset the last-served pointer SHALL be set to requester 1, so REQ0 wins the first simultaneous request.
REQ-032 If RST is asserted during RUN, no DONE pulse SHALL be produced.

Verification
REQ-033 Reset, then REQ0=1 with LIM0=3 -> next edge GNT0=1, Q=0; Q sequence 0,1,2,3; then FIN with DONE0=1, Q=3; then IDLE.
REQ-034 Reset, then REQ0=REQ1=1 held, LIM0=1, LIM1=2 -> requester 0 granted first, one IDLE cycle, then requester 1 granted (Q 0,1,2, DONE1); then requester 0 granted again.
REQ-035 LIM1=15 granted, ABORT=1 when Q=5 -> next edge IDLE, Q=5, GNT1=0, DONE1 never asserted.
REQ-036 LIM0=0 -> RUN one cycle with Q=0, DONE0 on the following cycle; a separate LIM0=15 run -> Q counts to 15 with no wrap.
REQ-037 LIM0 changed from 4 to 9 at Q=2 -> run ends at Q=4; RST=1 at Q=3 of a later run -> next edge all outputs 0 and no DONE.
